// File: rtl/fp_wb_pkg.sv
// Shared definitions for the FP register-file writeback path.
package fp_wb_pkg;

  localparam int FP_ADDR_W = 5;
  localparam int FP_DATA_W = 32;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } fp_wb_state_e;

endpackage : fp_wb_pkg

// File: rtl/fp_wb_port_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester at or above ptr wins,
// otherwise the lowest-indexed requester wins (wrap-around).
module rr_arbiter
  import fp_wb_pkg::*;
#(
  parameter int N     = 3,
  parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     grant,
  output logic [PTR_W-1:0] grant_idx,
  output logic             any
);

  logic [N-1:0]     w_mask;
  logic [N-1:0]     w_sel;
  logic [PTR_W-1:0] w_idx;

  // Mask off requesters below ptr, fall back to the unmasked set, pick lowest
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (PTR_W'(i) >= ptr);
    end
    w_sel = ((req & w_mask) != '0) ? (req & w_mask) : req;
    w_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_idx = w_sel[i] ? PTR_W'(i) : w_idx;
    end
    any       = (req != '0);
    grant_idx = w_idx;
    grant     = any ? (N'(1) << w_idx) : '0;
  end

endmodule : rr_arbiter

// File: rtl/fp_wb_port_arbiter.sv
// Single write port of the FP register file: zero-fills the file after reset or
// clear_req, then grants one writeback requester per cycle in round-robin order.
module fp_wb_port_arbiter
  import fp_wb_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = FP_DATA_W,
  parameter int ADDR_W  = FP_ADDR_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_req,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      reg_write,
  output logic [ADDR_W-1:0]         write_reg,
  output logic [DATA_W-1:0]         write_data,
  output logic                      init_done
);

  localparam int                PTR_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_REQ - 1);

  fp_wb_state_e      r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_init_cnt, w_init_cnt_nxt;
  logic [PTR_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
  logic              r_reg_write, w_reg_write_nxt;
  logic [ADDR_W-1:0] r_write_reg, w_write_reg_nxt;
  logic [DATA_W-1:0] r_write_data, w_write_data_nxt;
  logic              r_init_done, w_init_done_nxt;

  logic [NUM_REQ-1:0] w_grant;
  logic [PTR_W-1:0]   w_grant_idx;
  logic               w_any;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_data;
  logic               w_can_grant;

  rr_arbiter #(.N(NUM_REQ), .PTR_W(PTR_W)) u_rr (
    .req       (req_valid),
    .ptr       (r_rr_ptr),
    .grant     (w_grant),
    .grant_idx (w_grant_idx),
    .any       (w_any)
  );

  assign w_sel_addr  = req_addr[w_grant_idx*ADDR_W +: ADDR_W];
  assign w_sel_data  = req_data[w_grant_idx*DATA_W +: DATA_W];
  assign w_can_grant = (r_state == ST_RUN) && !clear_req;

  // Grant is only visible in RUN and never in the cycle a clear is requested
  always_comb begin
    if (w_can_grant) begin
      req_ready = w_grant;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and next-output logic for init sweep and arbitration
  always_comb begin
    w_state_nxt      = r_state;
    w_init_cnt_nxt   = r_init_cnt;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_reg_write_nxt  = r_reg_write;
    w_write_reg_nxt  = r_write_reg;
    w_write_data_nxt = r_write_data;
    w_init_done_nxt  = r_init_done;
    case (r_state)
      ST_INIT: begin
        w_reg_write_nxt  = 1'b1;
        w_write_data_nxt = '0;
        if (clear_req) begin
          w_write_reg_nxt = '0;
          w_init_cnt_nxt  = ADDR_W'(1);
        end else begin
          w_write_reg_nxt = r_init_cnt;
          if (r_init_cnt == LAST_ADDR) begin
            w_state_nxt     = ST_RUN;
            w_init_done_nxt = 1'b1;
            w_init_cnt_nxt  = '0;
          end else begin
            w_init_cnt_nxt  = r_init_cnt + ADDR_W'(1);
          end
        end
      end
      ST_RUN: begin
        if (clear_req) begin
          w_state_nxt     = ST_INIT;
          w_init_done_nxt = 1'b0;
          w_init_cnt_nxt  = '0;
          w_reg_write_nxt = 1'b0;
        end else if (w_any) begin
          w_reg_write_nxt  = 1'b1;
          w_write_reg_nxt  = w_sel_addr;
          w_write_data_nxt = w_sel_data;
          w_rr_ptr_nxt     = (w_grant_idx == LAST_PTR) ? '0 : (w_grant_idx + PTR_W'(1));
        end else begin
          w_reg_write_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = ST_INIT;
        w_init_cnt_nxt  = '0;
        w_reg_write_nxt = 1'b0;
        w_init_done_nxt = 1'b0;
      end
    endcase
  end

  // State and registered write-port outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_INIT;
      r_init_cnt   <= '0;
      r_rr_ptr     <= '0;
      r_reg_write  <= 1'b0;
      r_write_reg  <= '0;
      r_write_data <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_init_cnt   <= w_init_cnt_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
      r_reg_write  <= w_reg_write_nxt;
      r_write_reg  <= w_write_reg_nxt;
      r_write_data <= w_write_data_nxt;
      r_init_done  <= w_init_done_nxt;
    end
  end

  assign reg_write  = r_reg_write;
  assign write_reg  = r_write_reg;
  assign write_data = r_write_data;
  assign init_done  = r_init_done;

endmodule : fp_wb_port_arbiter

// File: tb/tb_fp_wb_port_arbiter.sv
// Directed and randomized checks of fp_wb_port_arbiter against a cycle-level
// behavioural model of the init sweep and round-robin write port.
module tb_fp_wb_port_arbiter;

  localparam int N     = 3;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 1 << AW;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            clear_req = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_data = '0;
  logic [N-1:0]    req_ready;
  logic            reg_write;
  logic [AW-1:0]   write_reg;
  logic [DW-1:0]   write_data;
  logic            init_done;

  int errors = 0;
  int checks = 0;

  // model state
  bit            m_run;
  int            m_idx;
  int            m_ptr;
  logic          m_we;
  logic [AW-1:0] m_wa;
  logic [DW-1:0] m_wd;
  logic          m_done;

  fp_wb_port_arbiter #(.NUM_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_req  (clear_req),
    .req_valid  (req_valid),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .reg_write  (reg_write),
    .write_reg  (write_reg),
    .write_data (write_data),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_idx = 0; m_ptr = 0;
    m_we = 1'b0; m_wa = '0; m_wd = '0; m_done = 1'b0;
  endtask

  function automatic int model_grant();
    if (!m_run || clear_req) return -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (req_valid[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_outs(input string tag);
    check({tag, "_we"},   64'(reg_write),  64'(m_we));
    check({tag, "_addr"}, 64'(write_reg),  64'(m_wa));
    check({tag, "_data"}, 64'(write_data), 64'(m_wd));
    check({tag, "_done"}, 64'(init_done),  64'(m_done));
  endtask

  // called just after a falling edge with inputs already applied
  task automatic step(input string tag);
    int g;
    #1;
    g = model_grant();
    check({tag, "_ready"}, 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    if (!m_run) begin
      if (clear_req) m_idx = 0;
      m_we = 1'b1; m_wa = AW'(m_idx); m_wd = '0;
      m_idx++;
      if (m_idx == DEPTH) begin
        m_run = 1'b1; m_done = 1'b1; m_idx = 0;
      end
    end else if (clear_req) begin
      m_run = 1'b0; m_done = 1'b0; m_we = 1'b0; m_idx = 0;
    end else if (g >= 0) begin
      m_we = 1'b1;
      m_wa = req_addr[g*AW +: AW];
      m_wd = req_data[g*DW +: DW];
      m_ptr = (g + 1) % N;
    end else begin
      m_we = 1'b0;
    end
    #1;
    check_outs(tag);
    if (g >= 0) req_valid[g] = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[i] = 1'b1;
    req_addr[i*AW +: AW] = a;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic fill(input int pct);
    for (int i = 0; i < N; i++) begin
      if (!req_valid[i] && ($urandom_range(99, 0) < pct))
        set_req(i, AW'($urandom), $urandom);
    end
  endtask

  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_outs(tag);
    check({tag, "_ready"}, 64'(req_ready), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #2;
    check_outs("rst");
    check("rst_ready", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check_outs("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;

    // init sweep with requesters already pushing: no grants until done
    for (int c = 0; c < DEPTH; c++) begin
      fill(60);
      step("init");
    end
    check("init_done_after_sweep", 64'(init_done), 64'd1);
    req_valid = '0;
    step("idle");

    // single requester
    set_req(1, AW'(7), 32'h3F80_0000);
    step("single");
    check("single_addr", 64'(write_reg), 64'd7);

    // one requester over three cycles, pointer wraps
    for (int c = 0; c < 3; c++) begin
      set_req(2, AW'($urandom), $urandom);
      step("hold2");
    end

    // all three continuously valid
    for (int c = 0; c < 6; c++) begin
      fill(100);
      step("fair");
    end
    req_valid = '0;

    // two writes to the same register
    set_req(0, AW'(3), 32'hAAAA_0000);
    set_req(1, AW'(3), 32'hBBBB_1111);
    step("same_a");
    step("same_b");
    check("same_last_data", 64'(write_data), 64'hBBBB_1111);

    // randomized traffic with occasional clears
    for (int c = 0; c < 300; c++) begin
      fill(int'($urandom_range(90, 10)));
      clear_req = ($urandom_range(59, 0) == 0);
      step("rand");
      clear_req = 1'b0;
    end
    while (!m_run) step("rand_drain");

    // clear in RUN with req0 pending
    req_valid = '0;
    set_req(0, AW'(21), 32'h1234_5678);
    clear_req = 1'b1;
    step("clr");
    clear_req = 1'b0;
    for (int c = 0; c < DEPTH; c++) step("clr_init");
    step("clr_grant0");
    check("clr_grant0_addr", 64'(write_reg), 64'd21);

    // reset mid-init at address 12
    async_reset("rst_run0");
    for (int c = 0; c < 13; c++) step("pre12");
    check("at12", 64'(write_reg), 64'd12);
    async_reset("rst_init12");
    for (int c = 0; c < DEPTH; c++) step("reinit");

    // reset mid-RUN with traffic
    for (int c = 0; c < 5; c++) begin
      fill(80);
      step("run_pre");
    end
    async_reset("rst_run");
    step("after_rst");
    check("after_rst_addr0", 64'(write_reg), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fp_wb_port_arbiter
